// File: rtl/conf_loader.sv
// Host-side configuration initiator: turns a 32-bit command stream into memory
// configuration-port strobes and returns read data / acknowledgements on a response stream.
module conf_loader #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        conf_sel,
    output logic        conf_rden,
    output logic        conf_wren,
    output logic [31:0] conf_addr,
    output logic [31:0] conf_wdata,
    input  logic [31:0] conf_rdata
);

    localparam logic [3:0] OP_WRITE = 4'h1;
    localparam logic [3:0] OP_READ  = 4'h2;
    localparam logic [3:0] OP_START = 4'h3;
    localparam logic [3:0] OP_HALT  = 4'h4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WR_DATA,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RD_RSP,
        S_ACK
    } state_t;

    state_t      state_q, state_d;
    logic        run_q;
    logic [3:0]  op_q;
    logic [15:0] n_q;
    logic [15:0] cnt_q;
    logic [31:0] addr_q;
    logic [1:0]  wait_q;

    logic [3:0]  hdr_op;
    logic [15:0] hdr_n;
    logic        hdr_xfer;
    logic        cmd_fire;
    logic        last_wait;
    logic        unused_hdr;

    assign hdr_op     = cmd_data[31:28];
    assign hdr_n      = cmd_data[15:0];
    assign hdr_xfer   = (hdr_op == OP_WRITE) || (hdr_op == OP_READ);
    assign unused_hdr = ^cmd_data[27:16];
    assign last_wait  = (wait_q == 2'(RD_LAT - 1));

    // run_q keeps cmd_ready low while in reset and for the first cycle after it.
    assign cmd_ready = run_q &&
                       ((state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_WR_DATA));
    assign cmd_fire  = cmd_valid && cmd_ready;

    // Transfers issued while the core runs are sequenced but reported with op 4'hE.
    function automatic logic [31:0] ack_word(input logic [3:0] op, input logic sel,
                                             input logic [15:0] n);
        return {(sel ? op : 4'hE), 12'h000, n};
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     if (cmd_fire) state_d = hdr_xfer ? S_ADDR : S_ACK;
            S_ADDR: begin
                if (cmd_fire) begin
                    if (cnt_q == 16'd0)        state_d = S_ACK;
                    else if (op_q == OP_WRITE) state_d = S_WR_DATA;
                    else                       state_d = S_RD_ISSUE;
                end
            end
            S_WR_DATA:  if (cmd_fire && cnt_q == 16'd1) state_d = S_ACK;
            S_RD_ISSUE: state_d = S_RD_WAIT;
            S_RD_WAIT:  if (last_wait) state_d = S_RD_RSP;
            S_RD_RSP:   if (rsp_ready) state_d = (cnt_q == 16'd0) ? S_ACK : S_RD_ISSUE;
            S_ACK:      if (rsp_ready) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q      <= 1'b0;
            op_q       <= 4'h0;
            n_q        <= 16'h0;
            cnt_q      <= 16'h0;
            addr_q     <= 32'h0;
            wait_q     <= 2'd0;
            conf_sel   <= 1'b1;
            conf_wren  <= 1'b0;
            conf_rden  <= 1'b0;
            conf_addr  <= 32'h0;
            conf_wdata <= 32'h0;
            rsp_valid  <= 1'b0;
            rsp_data   <= 32'h0;
        end else begin
            run_q     <= 1'b1;
            conf_wren <= 1'b0;
            conf_rden <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_fire) begin
                        op_q  <= hdr_op;
                        n_q   <= hdr_n;
                        cnt_q <= hdr_n;
                        if (!hdr_xfer) begin
                            rsp_valid <= 1'b1;
                            if (hdr_op == OP_START || hdr_op == OP_HALT)
                                rsp_data <= {hdr_op, 12'h000, hdr_n};
                            else
                                rsp_data <= {4'hF, 12'h000, hdr_n};
                            if (hdr_op == OP_START) conf_sel <= 1'b0;
                            if (hdr_op == OP_HALT)  conf_sel <= 1'b1;
                        end
                    end
                end
                S_ADDR: begin
                    if (cmd_fire) begin
                        addr_q <= cmd_data;
                        if (cnt_q == 16'd0) begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= ack_word(op_q, conf_sel, n_q);
                        end else if (op_q == OP_READ) begin
                            conf_rden <= conf_sel;
                            conf_addr <= cmd_data;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (cmd_fire) begin
                        conf_wren  <= conf_sel;
                        conf_addr  <= addr_q;
                        conf_wdata <= cmd_data;
                        addr_q     <= addr_q + 32'd1;
                        cnt_q      <= cnt_q - 16'd1;
                        if (cnt_q == 16'd1) begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= ack_word(op_q, conf_sel, n_q);
                        end
                    end
                end
                // conf_rden is already high here; advance to the next word.
                S_RD_ISSUE: begin
                    addr_q <= addr_q + 32'd1;
                    cnt_q  <= cnt_q - 16'd1;
                    wait_q <= 2'd0;
                end
                S_RD_WAIT: begin
                    if (last_wait) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= conf_sel ? conf_rdata : 32'h0;
                    end else begin
                        wait_q <= wait_q + 2'd1;
                    end
                end
                S_RD_RSP: begin
                    if (rsp_ready) begin
                        if (cnt_q == 16'd0) begin
                            rsp_data <= ack_word(op_q, conf_sel, n_q);
                        end else begin
                            rsp_valid <= 1'b0;
                            conf_rden <= conf_sel;
                            conf_addr <= addr_q;
                        end
                    end
                end
                S_ACK: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
